// File: rtl/jt49_stereo_hpf_if.sv
// Bus between the jt49 PSG channel outputs and the stereo/high-pass post-processor.
// The producer drives the channel levels and controls; the filter returns stereo samples and status.
interface jt49_stereo_hpf_if;
    logic               sample;
    logic [7:0]         A;
    logic [7:0]         B;
    logic [7:0]         C;
    logic [1:0]         stereo_mode;
    logic               en_hpf;
    logic signed [15:0] left;
    logic signed [15:0] right;
    logic               out_valid;
    logic               busy;
    logic               overrun;

    modport master (
        output sample, A, B, C, stereo_mode, en_hpf,
        input  left, right, out_valid, busy, overrun
    );

    modport slave (
        input  sample, A, B, C, stereo_mode, en_hpf,
        output left, right, out_valid, busy, overrun
    );
endinterface

// File: rtl/jt49_stereo_hpf.sv
// Stereo panning plus per-side one-pole DC-blocking filter for the jt49 PSG.
// One sample takes MIX -> FILT_L -> FILT_R -> OUT; samples arriving while busy are dropped and flagged.
module jt49_stereo_hpf #(
    parameter int unsigned HPF_SHIFT = 10,
    parameter int unsigned ACC_W     = 19
) (
    input  logic              clk,
    input  logic              rst_n,
    jt49_stereo_hpf_if.slave  bus
);
    localparam int unsigned CH_W  = 8;
    localparam int unsigned MIX_W = 10;
    localparam int unsigned OUT_W = 16;

    localparam logic signed [ACC_W-1:0] POS_LIM = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] NEG_LIM = ACC_W'(-32768);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MIX,
        ST_FILT_L,
        ST_FILT_R,
        ST_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic [CH_W-1:0]          a_q, a_d, b_q, b_d, c_q, c_d;
    logic [1:0]               mode_q, mode_d;
    logic                     en_q, en_d;
    logic signed [ACC_W-1:0]  xl_q, xl_d, xr_q, xr_d;
    logic signed [ACC_W-1:0]  xl_prev_q, xl_prev_d, xr_prev_q, xr_prev_d;
    logic signed [ACC_W-1:0]  yl_q, yl_d, yr_q, yr_d;
    logic signed [OUT_W-1:0]  left_q, left_d, right_q, right_d;
    logic                     out_valid_q, out_valid_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;

    logic [MIX_W-1:0]         ma_c, mb_c, mc_c, mix_l_c, mix_r_c;

    // y <= x - x_prev + y - y/2^HPF_SHIFT, the shift flooring toward -inf
    function automatic logic signed [ACC_W-1:0] hpf_step(
        input logic signed [ACC_W-1:0] x,
        input logic signed [ACC_W-1:0] xp,
        input logic signed [ACC_W-1:0] y
    );
        return x - xp + y - (y >>> HPF_SHIFT);
    endfunction

    function automatic logic signed [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > POS_LIM)      return 16'sh7FFF;
        else if (v < NEG_LIM) return 16'sh8000;
        else                  return v[OUT_W-1:0];
    endfunction

    // Panning: the dominant channel is doubled on its side, B/C fill the centre
    always_comb begin
        ma_c    = MIX_W'(a_q);
        mb_c    = MIX_W'(b_q);
        mc_c    = MIX_W'(c_q);
        mix_l_c = '0;
        mix_r_c = '0;
        case (mode_q)
            2'd0: begin mix_l_c = ma_c + mb_c + mc_c; mix_r_c = ma_c + mb_c + mc_c; end
            2'd1: begin mix_l_c = (ma_c << 1) + mb_c; mix_r_c = (mc_c << 1) + mb_c; end
            2'd2: begin mix_l_c = (ma_c << 1) + mc_c; mix_r_c = (mb_c << 1) + mc_c; end
            default: begin mix_l_c = (mc_c << 1) + mb_c; mix_r_c = (ma_c << 1) + mb_c; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        mode_d      = mode_q;
        en_d        = en_q;
        xl_d        = xl_q;
        xr_d        = xr_q;
        xl_prev_d   = xl_prev_q;
        xr_prev_d   = xr_prev_q;
        yl_d        = yl_q;
        yr_d        = yr_q;
        left_d      = left_q;
        right_d     = right_q;
        out_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.sample) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    c_d     = bus.C;
                    mode_d  = bus.stereo_mode;
                    en_d    = bus.en_hpf;
                    state_d = ST_MIX;
                end
            end
            ST_MIX: begin
                xl_d    = ACC_W'({mix_l_c, 6'b0});
                xr_d    = ACC_W'({mix_r_c, 6'b0});
                state_d = ST_FILT_L;
            end
            ST_FILT_L: begin
                yl_d      = hpf_step(xl_q, xl_prev_q, yl_q);
                xl_prev_d = xl_q;
                state_d   = ST_FILT_R;
            end
            ST_FILT_R: begin
                yr_d        = hpf_step(xr_q, xr_prev_q, yr_q);
                xr_prev_d   = xr_q;
                // Registered here so left/right and out_valid appear together in OUT
                left_d      = en_q ? sat16(yl_q) : {1'b0, xl_q[OUT_W-1:1]};
                right_d     = en_q ? sat16(yr_d) : {1'b0, xr_q[OUT_W-1:1]};
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        overrun_d = bus.sample && (state_q != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            mode_q      <= '0;
            en_q        <= 1'b0;
            xl_q        <= '0;
            xr_q        <= '0;
            xl_prev_q   <= '0;
            xr_prev_q   <= '0;
            yl_q        <= '0;
            yr_q        <= '0;
            left_q      <= '0;
            right_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            mode_q      <= mode_d;
            en_q        <= en_d;
            xl_q        <= xl_d;
            xr_q        <= xr_d;
            xl_prev_q   <= xl_prev_d;
            xr_prev_q   <= xr_prev_d;
            yl_q        <= yl_d;
            yr_q        <= yr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.left      = left_q;
    assign bus.right     = right_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_jt49_stereo_hpf.sv
// Scoreboard bench for jt49_stereo_hpf: default filter pole plus a fast-pole (HPF_SHIFT=2) instance.
module tb_jt49_stereo_hpf;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jt49_stereo_hpf_if b10();
    jt49_stereo_hpf_if b2();

    jt49_stereo_hpf #(.HPF_SHIFT(10), .ACC_W(19)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
    jt49_stereo_hpf #(.HPF_SHIFT(2),  .ACC_W(19)) dut2  (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    typedef struct {
        logic signed [15:0] l;
        logic signed [15:0] r;
    } exp_t;

    exp_t q10[$];
    exp_t q2[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push10(input int l, input int r);
        exp_t e;
        e.l = 16'(l);
        e.r = 16'(r);
        q10.push_back(e);
    endtask

    task automatic push2(input int l, input int r);
        exp_t e;
        e.l = 16'(l);
        e.r = 16'(r);
        q2.push_back(e);
    endtask

    // Holds sample high for exactly one cycle; returns #1 after the capturing edge
    task automatic pulse(input bit use2, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [1:0] m, input bit en);
        if (use2) begin
            b2.A = a; b2.B = b; b2.C = c; b2.stereo_mode = m; b2.en_hpf = en; b2.sample = 1'b1;
        end else begin
            b10.A = a; b10.B = b; b10.C = c; b10.stereo_mode = m; b10.en_hpf = en; b10.sample = 1'b1;
        end
        @(posedge clk);
        #1;
        b10.sample = 1'b0;
        b2.sample  = 1'b0;
    endtask

    // Monitor: every out_valid must match the oldest expected sample
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (b10.out_valid === 1'b1) begin
                    if (q10.size() == 0) chk("unexpected_valid_10", 1, 0);
                    else begin
                        e = q10.pop_front();
                        chk("left_10", b10.left, e.l);
                        chk("right_10", b10.right, e.r);
                    end
                end
                if (b2.out_valid === 1'b1) begin
                    if (q2.size() == 0) chk("unexpected_valid_2", 1, 0);
                    else begin
                        e = q2.pop_front();
                        chk("left_2", b2.left, e.l);
                        chk("right_2", b2.right, e.r);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        b10.sample = 1'b0; b10.A = '0; b10.B = '0; b10.C = '0; b10.stereo_mode = '0; b10.en_hpf = 1'b0;
        b2.sample  = 1'b0; b2.A  = '0; b2.B  = '0; b2.C  = '0; b2.stereo_mode  = '0; b2.en_hpf  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_left", b10.left, 0);
        chk("rst_right", b10.right, 0);
        chk("rst_valid", 32'(b10.out_valid), 0);
        chk("rst_busy", 32'(b10.busy), 0);
        chk("rst_overrun", 32'(b10.overrun), 0);
        rst_n = 1'b1;
        cyc(2);

        // Saturation from reset: y=48960 then 48913, both clip
        push10(32767, 32767);
        pulse(0, 8'hFF, 8'hFF, 8'hFF, 2'd0, 1'b1);
        cyc(5);
        push10(32767, 32767);
        pulse(0, 8'hFF, 8'hFF, 8'hFF, 2'd0, 1'b1);
        cyc(5);

        // Bypass mono with latency/busy window
        push10(3072, 3072);
        pulse(0, 8'h10, 8'h20, 8'h30, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk("busy_window", 32'(b10.busy), 1);
            chk("valid_latency", 32'(b10.out_valid), (i == 3) ? 1 : 0);
            cyc(1);
        end
        chk("busy_after", 32'(b10.busy), 0);
        chk("valid_after", 32'(b10.out_valid), 0);
        cyc(1);

        // Panning in bypass
        push10(4096, 0);
        pulse(0, 8'h40, 8'h00, 8'h00, 2'd1, 1'b0);
        cyc(5);
        push10(0, 4096);
        pulse(0, 8'h40, 8'h00, 8'h00, 2'd3, 1'b0);
        cyc(5);
        push10(4352, 1280);
        pulse(0, 8'h40, 8'h10, 8'h08, 2'd2, 1'b0);
        cyc(5);

        // Overrun: samples during MIX..OUT are dropped; next IDLE sample accepted
        push10(192, 192);
        pulse(0, 8'h01, 8'h02, 8'h03, 2'd0, 1'b0);      // n -> now at n+1
        cyc(1);                                         // n+2
        pulse(0, 8'hFF, 8'hFF, 8'hFF, 2'd1, 1'b0);      // ignored -> now n+3
        chk("overrun_n3", 32'(b10.overrun), 1);
        cyc(1);                                         // n+4 (OUT)
        chk("overrun_n4", 32'(b10.overrun), 0);
        pulse(0, 8'hFF, 8'h00, 8'h00, 2'd0, 1'b0);      // sample in OUT -> now n+5
        chk("overrun_out", 32'(b10.overrun), 1);
        chk("idle_n5", 32'(b10.busy), 0);
        push10(512, 512);
        pulse(0, 8'h10, 8'h00, 8'h00, 2'd0, 1'b0);      // accepted at n+5 -> now n+6
        cyc(3);                                         // n+9
        chk("valid_n9", 32'(b10.out_valid), 1);
        cyc(3);

        // Fast-pole decay: 1024, 768, 576, then input step down to -592
        push2(1024, 1024);
        pulse(1, 8'h10, 8'h00, 8'h00, 2'd0, 1'b1);
        cyc(5);
        push2(768, 768);
        pulse(1, 8'h10, 8'h00, 8'h00, 2'd0, 1'b1);
        cyc(5);
        push2(576, 576);
        pulse(1, 8'h10, 8'h00, 8'h00, 2'd0, 1'b1);
        cyc(5);
        push2(-592, -592);
        pulse(1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1);
        cyc(5);

        // Reset during FILT_L: outputs clear at once, the aborted sample never emerges
        pulse(0, 8'h20, 8'h00, 8'h00, 2'd0, 1'b0);
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("midrst_left", b10.left, 0);
        chk("midrst_right", b10.right, 0);
        chk("midrst_valid", 32'(b10.out_valid), 0);
        chk("midrst_busy", 32'(b10.busy), 0);
        chk("midrst_left2", b2.left, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(10);

        // Filter state cleared by reset: first filtered sample is a step from zero
        push10(1024, 1024);
        pulse(0, 8'h10, 8'h00, 8'h00, 2'd0, 1'b1);
        cyc(6);

        chk("q10_drained", q10.size(), 0);
        chk("q2_drained", q2.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/jt49_stereo_hpf.md
Name: jt49_stereo_hpf

Overview:
- Post-processing stage directly downstream of the jt49 PSG.
- Consumes the linearised per-channel outputs A/B/C and the `sample` strobe (cen16). Pans them into a stereo pair (mono/ABC/ACB/CBA), removes DC with a one-pole high-pass filter per side, and delivers saturated signed 16-bit left/right samples with a valid pulse to the audio DAC/I2S stage.

Parameters:
- HPF_SHIFT, 10, filter pole: y -= y>>>HPF_SHIFT each sample (corner ≈ fs/(2π·2^HPF_SHIFT)).
- ACC_W, 19, signed width of internal filter state/arith (must be ≥19).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- sample  in  1  one-cycle strobe, channel values valid this cycle.
- A  in  8  channel A linear level (unsigned).
- B  in  8  channel B linear level.
- C  in  8  channel C linear level.
- stereo_mode  in  2  0 mono, 1 ABC, 2 ACB, 3 CBA; sampled with `sample`.
- en_hpf  in  1  1 filtered output, 0 bypass; sampled with `sample`.
- left  out  16  signed left sample.
- right  out  16  signed right sample.
- out_valid  out  1  one-cycle pulse, left/right updated this cycle.
- busy  out  1  high while FSM not IDLE.
- overrun  out  1  one-cycle pulse when `sample` arrives while busy.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; left=right=0; out_valid=busy=overrun=0; all filter state (xl_prev, xr_prev, yl, yr) = 0.
- FSM: IDLE -> MIX -> FILT_L -> FILT_R -> OUT -> IDLE, one state per clk.
  - IDLE: on sample=1, latch A,B,C,stereo_mode,en_hpf; go MIX.
  - MIX: compute 10-bit unsigned sums.
    - mono: L=R=A+B+C.
    - ABC: L=2A+B, R=2C+B.
    - ACB: L=2A+C, R=2B+C.
    - CBA: L=2C+B, R=2A+B.
    - Max 765 in every mode.
  - MIX also forms xL=L<<6, xR=R<<6 (0..48960, zero-extended to ACC_W).
  - FILT_L: yl <= xL - xl_prev + yl - (yl>>>HPF_SHIFT) (arithmetic shift, floors toward -inf); xl_prev <= xL.
  - FILT_R: same for right side.
  - OUT: if en_hpf latched 1, left/right = sat16(yl/yr). If 0, left/right = {1'b0, xL[15:1]} / {1'b0, xR[15:1]}.
  - OUT pulses out_valid and returns to IDLE.
- Filter state updates every sample regardless of en_hpf, so toggling bypass causes no transient beyond the selection change.
- sat16: values >32767 -> 32767; values < -32768 -> -32768; otherwise truncate to 16 bits.
- Latency: sample at cycle n -> out_valid at cycle n+4. busy is high cycles n+1..n+4.
- left/right hold between out_valid pulses.
- Sample while busy (n+1..n+4): input ignored, nothing latched, overrun pulses the following cycle, current computation completes unaffected.
- Sample in the same cycle as OUT (FSM still OUT): counts as busy -> overrun. The next sample is accepted only from IDLE.
- Reset mid-operation: immediate return to reset state, no out_valid.
- Inputs A/B/C may change freely when sample=0.
- After reset the first sample sees x_prev=0 (step from zero). This is intended.

Test Plan:
- Reset: assert rst_n=0 mid-FILT_L -> left=right=0, out_valid=0, busy=0 immediately; no out_valid follows after release.
- Bypass mono: en_hpf=0, mode=0, A=0x10, B=0x20, C=0x30, pulse sample at n -> out_valid at n+4, left=right=3072, busy high n+1..n+4.
- Bypass panning: en_hpf=0, mode=1, A=0x40, B=0, C=0 -> left=4096, right=0. Same with mode=3 -> left=0, right=4096.
- HPF decay: HPF_SHIFT=2, en_hpf=1, mono, A=0x10, B=C=0, sample ×3 -> left=right=1024, 768, 576. Then A=0 -> -592.
- Saturation: HPF_SHIFT=10, en_hpf=1, mono, A=B=C=0xFF from reset -> first output left=right=32767 (y=48960); second 32767 (y=48913).
- Overrun: sample at n and n+2 -> overrun pulse at n+3, single out_valid at n+4 with values from first sample. Sample at n+5 is accepted, out_valid at n+9.
